// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 constants, state encoding and bit functions
package sha256_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

  localparam int WORD_W     = 32;
  localparam int WIN_DEPTH  = 16;
  localparam int MAX_ROUNDS = 64;

  // Round constants: first 32 bits of the fractional parts of the cube roots of the first 64 primes
  localparam logic [31:0] K_TABLE [MAX_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Message schedule small sigmas
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Compression round helpers for the downstream datapath
  function automatic logic [31:0] big_sig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// rtl/sha256_k_rom.sv - combinational K_t constant lookup
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  addr_i,
  output logic [31:0] k_o
);

  // Pure table read; no register so K_t lines up with the round index in the same cycle
  always_comb begin
    k_o = K_TABLE[addr_i];
  end

endmodule

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message schedule feeder emitting (W_t, K_t) pairs
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] blk_word,
  input  logic        blk_valid,
  output logic        blk_ready,
  output logic [31:0] w_out,
  output logic [31:0] k_out,
  output logic [5:0]  round_idx,
  output logic        w_valid,
  input  logic        w_ready,
  output logic        last_round,
  output logic        busy
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  sched_state_e state_q, state_d;
  logic [3:0]   load_cnt_q, load_cnt_d;
  logic [5:0]   round_idx_q, round_idx_d;
  logic [31:0]  win_q [WIN_DEPTH];
  logic         shift_en;
  logic [31:0]  shift_word;
  logic [31:0]  w_next;

  // Window holds W_t..W_t+15, so W_t+16 depends only on fixed taps 0, 1, 9 and 14
  always_comb begin
    w_next = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
  end

  sha256_k_rom u_k_rom (
    .addr_i (round_idx_q),
    .k_o    (k_out)
  );

  assign blk_ready  = (state_q == ST_LOAD);
  assign w_valid    = (state_q == ST_RUN);
  assign w_out      = win_q[0];
  assign round_idx  = round_idx_q;
  assign last_round = w_valid && (round_idx_q == LAST_IDX);
  assign busy       = (state_q != ST_LOAD) || (load_cnt_q != 4'd0);

  // State, load counter and round index registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      load_cnt_q  <= 4'd0;
      round_idx_q <= 6'd0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      round_idx_q <= round_idx_d;
    end
  end

  // Next-state logic: loading shifts in message words, running shifts in expanded words
  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    round_idx_d = round_idx_q;
    shift_en    = 1'b0;
    shift_word  = 32'd0;
    case (state_q)
      ST_LOAD: begin
        if (blk_valid) begin
          shift_en   = 1'b1;
          shift_word = blk_word;
          if (load_cnt_q == 4'd15) begin
            load_cnt_d  = 4'd0;
            round_idx_d = 6'd0;
            state_d     = ST_RUN;
          end else begin
            load_cnt_d = load_cnt_q + 4'd1;
          end
        end
      end
      ST_RUN: begin
        if (w_ready) begin
          shift_en   = 1'b1;
          shift_word = w_next;
          if (round_idx_q == LAST_IDX) begin
            round_idx_d = 6'd0;
            state_d     = ST_LOAD;
          end else begin
            round_idx_d = round_idx_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Sliding 16-word window; a stall leaves it untouched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_DEPTH; i++) begin
        win_q[i] <= 32'd0;
      end
    end else if (shift_en) begin
      for (int i = 0; i < WIN_DEPTH - 1; i++) begin
        win_q[i] <= win_q[i+1];
      end
      win_q[WIN_DEPTH-1] <= shift_word;
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - randomized self-checking bench against a software schedule model
module tb_sha256_msg_schedule;

  logic        clk;
  logic        rst_n;
  logic [31:0] blk_word;
  logic        blk_valid;
  logic        w_ready;
  logic        sel;

  logic        br64, wv64, last64, busy64;
  logic [31:0] w64, k64;
  logic [5:0]  idx64;
  logic        br16, wv16, last16, busy16;
  logic [31:0] w16, k16;
  logic [5:0]  idx16;

  logic        o_br, o_wv, o_last, o_busy;
  logic [31:0] o_w, o_k;
  logic [5:0]  o_idx;

  int checks;
  int failures;

  logic [31:0] blocks [2][16];
  logic [31:0] exp_w [64];

  localparam logic [31:0] K_REF [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_msg_schedule #(.ROUNDS(64)) dut64 (
    .clk        (clk),
    .rst_n      (rst_n),
    .blk_word   (blk_word),
    .blk_valid  (blk_valid),
    .blk_ready  (br64),
    .w_out      (w64),
    .k_out      (k64),
    .round_idx  (idx64),
    .w_valid    (wv64),
    .w_ready    (w_ready),
    .last_round (last64),
    .busy       (busy64)
  );

  sha256_msg_schedule #(.ROUNDS(16)) dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .blk_word   (blk_word),
    .blk_valid  (blk_valid),
    .blk_ready  (br16),
    .w_out      (w16),
    .k_out      (k16),
    .round_idx  (idx16),
    .w_valid    (wv16),
    .w_ready    (w_ready),
    .last_round (last16),
    .busy       (busy16)
  );

  assign o_br   = sel ? br16   : br64;
  assign o_wv   = sel ? wv16   : wv64;
  assign o_last = sel ? last16 : last64;
  assign o_busy = sel ? busy16 : busy64;
  assign o_w    = sel ? w16    : w64;
  assign o_k    = sel ? k16    : k64;
  assign o_idx  = sel ? idx16  : idx64;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model(input int b);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = blocks[b][t];
      else exp_w[t] = ss1(exp_w[t-2]) + exp_w[t-7] + ss0(exp_w[t-15]) + exp_w[t-16];
    end
  endtask

  task automatic rand_block(input int b);
    for (int i = 0; i < 16; i++) blocks[b][i] = $urandom();
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_w_valid"}, 32'(o_wv), 32'd0);
    check_eq({tag, "_blk_ready"}, 32'(o_br), 32'd1);
    check_eq({tag, "_round_idx"}, 32'(o_idx), 32'd0);
    check_eq({tag, "_busy"}, 32'(o_busy), 32'd0);
    check_eq({tag, "_last_round"}, 32'(o_last), 32'd0);
  endtask

  // Called and returns at a falling edge; reset held across exactly one rising edge
  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    blk_valid = 1'b0;
    w_ready = 1'b0;
    @(negedge clk);
    check_idle(tag);
    check_eq({tag, "_w_out"}, o_w, 32'd0);
    check_eq({tag, "_k_out"}, o_k, 32'h428a2f98);
    rst_n = 1'b1;
  endtask

  task automatic load_block(input int b, input int n);
    int i;
    int cyc;
    i = 0;
    cyc = 0;
    while (i < n && cyc < 200) begin
      if (i > 0) check_eq("busy_load", 32'(o_busy), 32'd1);
      if (i < 16) check_eq("w_valid_load", 32'(o_wv), 32'd0);
      blk_word = blocks[b][i];
      blk_valid = 1'b1;
      if (o_br) i++;
      @(negedge clk);
      cyc++;
    end
    blk_valid = 1'b0;
    check_eq("load_done", 32'(i), 32'(n));
  endtask

  task automatic run_block(input int n, input bit rand_rdy, input bit abc, input bit offer, input int nb);
    int t;
    int cyc;
    int rounds;
    bit rdy;
    t = 0;
    cyc = 0;
    rounds = sel ? 16 : 64;
    blk_valid = offer;
    blk_word = offer ? blocks[nb][0] : 32'd0;
    while (t < n && cyc < 2000) begin
      check_eq("w_valid", 32'(o_wv), 32'd1);
      check_eq("blk_ready_run", 32'(o_br), 32'd0);
      check_eq("busy_run", 32'(o_busy), 32'd1);
      check_eq("round_idx", 32'(o_idx), 32'(t));
      check_eq("w_out", o_w, exp_w[t]);
      check_eq("k_out", o_k, K_REF[t]);
      check_eq("last_round", 32'(o_last), 32'(t == rounds - 1));
      if (abc) begin
        if (t == 0)  check_eq("abc_w0", o_w, 32'h61626380);
        if (t == 15) check_eq("abc_w15", o_w, 32'h00000018);
        if (t == 16) check_eq("abc_w16", o_w, 32'h61626380);
        if (t == 17) check_eq("abc_w17", o_w, 32'h000f0000);
        if (t == 63) check_eq("abc_k63", o_k, 32'hc67178f2);
      end
      rdy = rand_rdy ? ($urandom_range(0, 1) != 0) : 1'b1;
      w_ready = rdy;
      if (rdy) t++;
      @(negedge clk);
      cyc++;
    end
    w_ready = 1'b0;
    check_eq("run_done", 32'(t), 32'(n));
    if (n == rounds) check_idle("after_run");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    sel = 1'b0;
    rst_n = 1'b0;
    blk_valid = 1'b0;
    blk_word = 32'd0;
    w_ready = 1'b0;
    blocks[0][0] = 32'h61626380;
    for (int i = 1; i < 15; i++) blocks[0][i] = 32'd0;
    blocks[0][15] = 32'h00000018;
    rand_block(1);

    @(negedge clk);
    apply_reset("reset");

    // "abc" block, always ready
    build_model(0);
    load_block(0, 16);
    run_block(64, 1'b0, 1'b1, 1'b0, 0);

    // Same block with random backpressure
    load_block(0, 16);
    run_block(64, 1'b1, 1'b1, 1'b0, 0);

    // Back-to-back: second block offered during RUN, loads right after the final handshake
    load_block(0, 16);
    run_block(64, 1'b1, 1'b1, 1'b1, 1);
    build_model(1);
    load_block(1, 16);
    run_block(64, 1'b0, 1'b0, 1'b0, 0);

    // Reset after a partial load leaves no stale words
    load_block(0, 7);
    apply_reset("reset_midload");
    build_model(0);
    load_block(0, 16);
    run_block(64, 1'b0, 1'b1, 1'b0, 0);

    // Reset in the middle of a run
    load_block(0, 16);
    run_block(30, 1'b0, 1'b0, 1'b0, 0);
    check_eq("idx_before_reset", 32'(o_idx), 32'd30);
    apply_reset("reset_midrun");

    // Random blocks, 64 rounds
    for (int r = 0; r < 3; r++) begin
      rand_block(1);
      build_model(1);
      load_block(1, 16);
      run_block(64, 1'b1, 1'b0, 1'b0, 0);
    end

    // Random blocks, 16 rounds
    sel = 1'b1;
    apply_reset("reset_r16");
    for (int r = 0; r < 3; r++) begin
      rand_block(1);
      build_model(1);
      load_block(1, 16);
      run_block(16, 1'b1, 1'b0, 1'b0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
